// File: rtl/spi_device_lite_pkg.sv
// Shared types and constants for the spi_device_lite SPI target.
package spi_device_lite_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam int ByteW      = 8;
    localparam int SyncStages = 2;

endpackage

// File: rtl/spi_device_lite_rxfifo.sv
// Synchronous FIFO with wrap-bit pointers; the head entry is presented straight from storage.
module spi_device_lite_rxfifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   depth
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign depth = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (depth == (AW+1)'(Depth));
    assign rdata = mem[rptr[AW-1:0]];

    // A pop frees a slot in the same cycle, so a push into a full FIFO succeeds alongside it.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_device_lite.sv
// Mode-0 SPI target: oversampled pins, RX byte FIFO and valid/ready TX byte source.
module spi_device_lite
    import spi_device_lite_pkg::*;
#(
    parameter int unsigned      RxDepth    = 4,
    parameter logic [ByteW-1:0] TxFillByte = 8'hFF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cio_sck_i,
    input  logic                      cio_csb_i,
    input  logic                      cio_sd_i,
    output logic                      cio_sd_o,
    output logic                      cio_sd_en_o,
    output logic [ByteW-1:0]          rx_data_o,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    output logic [$clog2(RxDepth):0]  rx_depth_o,
    input  logic [ByteW-1:0]          tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    output logic                      rx_overflow_o,
    output logic                      tx_underflow_o,
    output logic                      frame_abort_o
);

    logic [SyncStages:0]   sck_q;
    logic [SyncStages:0]   csb_q;
    logic [SyncStages-1:0] sd_q;
    logic                  sd_sync;
    logic                  sck_rise;
    logic                  sck_fall;
    logic                  csb_rise;
    logic                  csb_fall;

    state_e           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [ByteW-1:0] rx_shift_q, rx_shift_d;
    logic [ByteW-1:0] tx_shift_q, tx_shift_d;
    logic             tx_load;
    logic             rx_push;
    logic             rx_pop;
    logic             rx_full;
    logic             rx_empty;
    logic             abort;

    // Sync flops reset low so a CSB already low at reset release never yields a falling event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_q <= '0;
            csb_q <= '0;
            sd_q  <= '0;
        end else begin
            sck_q <= {sck_q[SyncStages-1:0], cio_sck_i};
            csb_q <= {csb_q[SyncStages-1:0], cio_csb_i};
            sd_q  <= {sd_q[SyncStages-2:0], cio_sd_i};
        end
    end

    assign sd_sync  = sd_q[SyncStages-1];
    assign sck_rise = ~rst_i &  sck_q[SyncStages-1] & ~sck_q[SyncStages];
    assign sck_fall = ~rst_i & ~sck_q[SyncStages-1] &  sck_q[SyncStages];
    assign csb_rise = ~rst_i &  csb_q[SyncStages-1] & ~csb_q[SyncStages];
    assign csb_fall = ~rst_i & ~csb_q[SyncStages-1] &  csb_q[SyncStages];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_load    = 1'b0;
        rx_push    = 1'b0;
        abort      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (csb_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    tx_load   = 1'b1;
                end
            end
            ACTIVE: begin
                // CSB rising wins over any SCK edge seen in the same cycle.
                if (csb_rise) begin
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    abort      = (bit_cnt_q != 3'd0);
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[ByteW-2:0], sd_sync};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    rx_push    = (bit_cnt_q == 3'd7);
                end else if (sck_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        tx_load = 1'b1;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (tx_load) begin
            tx_shift_d = tx_valid_i ? tx_data_i : TxFillByte;
        end
    end

    assign cio_sd_en_o    = (state_q == ACTIVE);
    assign cio_sd_o       = (state_q == ACTIVE) & tx_shift_q[ByteW-1];
    assign tx_ready_o     = tx_load & tx_valid_i;
    assign tx_underflow_o = tx_load & ~tx_valid_i;
    assign frame_abort_o  = abort;

    assign rx_valid_o    = ~rx_empty;
    assign rx_pop        = rx_ready_i & rx_valid_o;
    assign rx_overflow_o = rx_push & rx_full & ~rx_pop;

    spi_device_lite_rxfifo #(
        .Depth (RxDepth),
        .Width (ByteW)
    ) u_rxfifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (rx_push),
        .wdata (rx_shift_d),
        .pop   (rx_pop),
        .rdata (rx_data_o),
        .full  (rx_full),
        .empty (rx_empty),
        .depth (rx_depth_o)
    );

endmodule
